// File: rtl/rng_share_arbiter_if.sv
// Requester-side bundle of the shared RNG: seeding, level requests and the
// one-cycle grant/random-byte response.
interface rng_share_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int LFSR_W = 16
);
  logic              seed_load;
  logic [LFSR_W-1:0] seed;
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  gnt;
  logic [7:0]        rnd;
  logic              rnd_valid;
  logic              busy;

  modport master (output seed_load, seed, req,
                  input  gnt, rnd, rnd_valid, busy);
  modport slave  (input  seed_load, seed, req,
                  output gnt, rnd, rnd_valid, busy);
endinterface

// File: rtl/rng_share_arbiter.sv
// Shares one Galois LFSR between N_REQ requesters. After reset or a seed load
// the LFSR is warmed up, then each round-robin grant advances it 8 steps and
// hands the low byte to the winner together with a one-cycle gnt/rnd_valid.
module rng_share_arbiter #(
  parameter int                N_REQ      = 4,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
  parameter logic [LFSR_W-1:0] RESET_SEED = 16'hACE1,
  parameter int                WARMUP     = 16
) (
  input  logic               clk,
  input  logic               rst,
  rng_share_arbiter_if.slave bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] WARM_LAST = (WARMUP > 0) ? CNT_W'(WARMUP - 1) : '0;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(7);

  typedef enum logic [1:0] {WARM, READY, STEP, DELIVER} state_e;

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d, win_q, win_d, pick;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [7:0]        rnd_q, rnd_d;
  logic              vld_q, vld_d;
  logic              any_req;
  int                idx;

  assign lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

  // Round-robin pick: scan downward so the requester closest above ptr wins.
  always_comb begin
    pick    = ptr_q;
    any_req = 1'b0;
    idx     = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (bus.req[idx]) begin
        pick    = PTR_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  // Next state, LFSR stepping, seed override and registered-output staging.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    case (state_q)
      WARM: begin
        if (WARMUP == 0) begin
          state_d = READY;
        end else begin
          lfsr_d = lfsr_nxt;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == WARM_LAST) state_d = READY;
        end
      end
      READY: begin
        if (any_req) begin
          win_d   = pick;
          cnt_d   = '0;
          state_d = STEP;
        end
      end
      STEP: begin
        lfsr_d = lfsr_nxt;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == STEP_LAST) state_d = DELIVER;
      end
      DELIVER: begin
        // The grant is already on the outputs this cycle, so the pointer
        // moves on even if a seed load arrives together with it.
        ptr_d   = (int'(win_q) == N_REQ - 1) ? '0 : win_q + 1'b1;
        state_d = READY;
      end
      default: state_d = WARM;
    endcase
    // Seed load aborts whatever is in flight; zero would lock the LFSR.
    if (bus.seed_load) begin
      lfsr_d  = (bus.seed == '0) ? LFSR_W'(1) : bus.seed;
      cnt_d   = '0;
      state_d = WARM;
    end
    gnt_d = '0;
    vld_d = 1'b0;
    rnd_d = rnd_q;
    if (state_d == DELIVER) begin
      gnt_d = N_REQ'(1) << win_q;
      vld_d = 1'b1;
      rnd_d = lfsr_d[7:0];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WARM;
      lfsr_q  <= RESET_SEED;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      rnd_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rnd       = rnd_q;
  assign bus.rnd_valid = vld_q;
  assign bus.busy      = (state_q != READY);
endmodule
